clk_ratio_monitor: RTL and testbench
====================================

Name: clk_ratio_monitor

Overview:
- Receive-side checker for divided clocks produced in the I_ref_clk domain.
- Samples a divided clock as data, measures its high time, low time and period in reference-clock cycles, and reports the effective integer division ratio.
- Asserts lock after a run of identical periods and flags ratio changes or a stalled clock.
- Sits beside the clock divider for self-check and status readback.

Parameters:
- CNT_W, 8: width of the phase counter and of the high/low measurements.
- LOCK_CNT, 3: number of consecutive identical periods, including the first, required to assert lock. Legal range is 2 or more.

Ports:
- I_ref_clk  input  1  reference clock; the only clock.
- I_rst_n  input  1  asynchronous reset, active low.
- I_mon_en  input  1  monitor enable.
- I_div_clk  input  1  divided clock under test. It is a register output in the I_ref_clk domain, so no synchroniser is used.
- o_high_cnt  output  CNT_W  high-phase length, in cycles, of the last complete period.
- o_low_cnt  output  CNT_W  low-phase length, in cycles, of the last complete period.
- o_ratio  output  CNT_W+1  o_high_cnt + o_low_cnt.
- o_valid  output  1  one-cycle pulse when new measurements are published.
- o_locked  output  1  high after LOCK_CNT consecutive identical ratios.
- o_err  output  1  one-cycle pulse on ratio change while locked, or on timeout.

Behaviour:
- Reset: all outputs are 0, state is S_IDLE, phase counter is 0, match counter is 0, and div_q is 0.
- div_q registers I_div_clk every cycle, whether or not the block is enabled.
  - rise = I_div_clk & ~div_q
  - fall = ~I_div_clk & div_q
- Phase counter:
  - Loads 1 on any edge.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - It therefore holds the number of samples of the level that just ended.
- States:
  - S_IDLE: counters are held. Moves to S_ACQ when I_mon_en=1.
  - S_ACQ: discards any partial phase. On rise, moves to S_HIGH.
  - S_HIGH: on fall, latches hi_len = phase counter and moves to S_LOW.
  - S_LOW: on rise, does all of the following in the same edge and returns to S_HIGH:
    - Publishes o_high_cnt=hi_len, o_low_cnt=phase counter and o_ratio=sum.
    - Pulses o_valid.
    - Updates the lock logic.
- Latency: o_valid is high in the cycle following the posedge at which I_div_clk is first sampled high. All outputs are registered.
- Lock logic, applied at each publish:
  - Ratio equals the previous published ratio: match counter increments, saturating at LOCK_CNT.
  - Ratio differs, or this is the first period after S_ACQ: match counter is set to 1.
  - o_locked = (match counter == LOCK_CNT).
  - A differing ratio while o_locked=1 pulses o_err in the same cycle as o_valid and clears o_locked.
- Timeout:
  - Condition: the phase counter reaches 2^CNT_W-1 in S_HIGH or S_LOW.
  - Response: pulse o_err, clear o_locked and the match counter, go to S_ACQ, publish nothing.
  - No timeout applies in S_ACQ or S_IDLE.
- Disable: I_mon_en=0 in any state sends the block to S_IDLE on the next edge.
  - o_locked and the match counter clear.
  - o_valid and o_err are 0.
  - The measurement outputs hold their last published values.
  - A partial period is never published.
- Simultaneous events:
  - Disable takes priority over edge handling and timeout.
  - An edge in the same cycle the counter would saturate is treated as an edge, not a timeout.
- Re-enable: always passes through S_ACQ. The first valid output comes only after a full rise-to-rise period.
- Minimum measurable period is 2: a toggle every cycle gives hi=1, lo=1.
- Odd ratios report asymmetric phases, e.g. 5 as 3+2 or 2+3.
- o_ratio never overflows because it is one bit wider than the phase counter.

Decomposition:
- Package clk_ratio_monitor_pkg holds:
  - the state enum (S_IDLE, S_ACQ, S_HIGH, S_LOW);
  - the default CNT_W;
  - localparam CNT_MAX = 2^CNT_W-1.
- One sub-module, clk_edge_detect: the div_q register plus the rise and fall outputs, reset to 0.
- The FSM, counters and lock logic stay in the top level.

Test Plan:
1. Startup with a symmetric period: enable, then drive I_div_clk toggling every 2 cycles.
   - o_valid every 4 cycles with o_ratio=4, o_high_cnt=2, o_low_cnt=2.
   - o_locked rises with the third o_valid.
2. Odd ratio: drive high 3 / low 2 repeatedly.
   - o_ratio=5, o_high_cnt=3, o_low_cnt=2.
   - Locked after 3 periods; o_err stays 0.
3. Ratio change after lock: lock on ratio 4, then switch to 3/3.
   - First o_ratio=6 comes with a 1-cycle o_err pulse and o_locked=0.
   - o_locked reasserts on the third period of 6.
4. Stuck clock: with the block locked, hold I_div_clk high for 300 cycles.
   - Exactly one o_err pulse, 255 cycles after the rise; o_locked=0.
   - No o_valid until the first complete period after the clock resumes.
5. Enable while high / mid-period disable:
   - Enable with I_div_clk already high: the first high phase is discarded.
   - Drop I_mon_en for 1 cycle mid-phase: no o_valid for the partial period, o_locked clears.
   - The measurement outputs keep their old values.
6. Asynchronous reset mid-period: assert I_rst_n=0 between clock edges.
   - All outputs go to 0 immediately.
   - After release and enable, the first o_valid arrives one full period after the first rise.

Source files
------------

// File: rtl/clk_ratio_monitor_pkg.sv
// rtl/clk_ratio_monitor_pkg.sv - shared types and constants for the divided-clock ratio monitor
package clk_ratio_monitor_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/clk_edge_detect.sv
// rtl/clk_edge_detect.sv - one-cycle rise/fall detect on a same-domain divided clock
module clk_edge_detect (
    input  logic I_ref_clk,
    input  logic I_rst_n,
    input  logic div_clk,
    output logic rise,
    output logic fall
);

    logic div_q;

    // The divided clock is a register output in this domain, so it is sampled directly.
    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_clk;
        end
    end

    assign rise = div_clk & ~div_q;
    assign fall = ~div_clk & div_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - measures high/low/period of a divided clock and reports lock
module clk_ratio_monitor
    import clk_ratio_monitor_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = 3
) (
    input  logic             I_ref_clk,
    input  logic             I_rst_n,
    input  logic             I_mon_en,
    input  logic             I_div_clk,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic [CNT_W:0]   o_ratio,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_err
);

    localparam int                 MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   PH_MAX     = '1;
    localparam logic [CNT_W-1:0]   PH_ONE     = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);

    logic                rise;
    logic                fall;
    logic                any_edge;
    logic                timeout;
    logic [CNT_W:0]      ratio_new;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]    hi_len_q, hi_len_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]    high_d;
    logic [CNT_W-1:0]    low_d;
    logic [CNT_W:0]      ratio_d;
    logic                valid_d;
    logic                locked_d;
    logic                err_d;

    clk_edge_detect u_edge (
        .I_ref_clk (I_ref_clk),
        .I_rst_n   (I_rst_n),
        .div_clk   (I_div_clk),
        .rise      (rise),
        .fall      (fall)
    );

    assign any_edge  = rise | fall;
    assign ratio_new = {1'b0, hi_len_q} + {1'b0, phase_q};
    // An edge arriving as the counter sits at its ceiling still counts as a measurement.
    assign timeout   = ((state_q == S_HIGH) || (state_q == S_LOW)) &&
                       (phase_q == PH_MAX) && !any_edge;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hi_len_d = hi_len_q;
        match_d  = match_q;
        high_d   = o_high_cnt;
        low_d    = o_low_cnt;
        ratio_d  = o_ratio;
        valid_d  = 1'b0;
        locked_d = o_locked;
        err_d    = 1'b0;

        if (!I_mon_en) begin
            state_d  = S_IDLE;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            if (state_q != S_IDLE) begin
                if (any_edge) begin
                    phase_d = PH_ONE;
                end else if (phase_q != PH_MAX) begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            if (timeout) begin
                err_d    = 1'b1;
                locked_d = 1'b0;
                match_d  = '0;
                state_d  = S_ACQ;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_ACQ;
                    S_ACQ: begin
                        if (rise) begin
                            state_d = S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            hi_len_d = phase_q;
                            state_d  = S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            high_d  = hi_len_q;
                            low_d   = phase_q;
                            ratio_d = ratio_new;
                            valid_d = 1'b1;
                            state_d = S_HIGH;
                            // match_q of zero marks the first period since acquisition.
                            if ((match_q != '0) && (ratio_new == o_ratio)) begin
                                if (match_q != MATCH_FULL) begin
                                    match_d = match_q + MATCH_ONE;
                                end
                            end else begin
                                match_d = MATCH_ONE;
                                err_d   = o_locked;
                            end
                            locked_d = (match_d == MATCH_FULL);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            hi_len_q   <= '0;
            match_q    <= '0;
            o_high_cnt <= '0;
            o_low_cnt  <= '0;
            o_ratio    <= '0;
            o_valid    <= 1'b0;
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hi_len_q   <= hi_len_d;
            match_q    <= match_d;
            o_high_cnt <= high_d;
            o_low_cnt  <= low_d;
            o_ratio    <= ratio_d;
            o_valid    <= valid_d;
            o_locked   <= locked_d;
            o_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - table-driven self-checking bench for clk_ratio_monitor
module tb_clk_ratio_monitor;
    import clk_ratio_monitor_pkg::*;

    logic       I_ref_clk;
    logic       I_rst_n;
    logic       I_mon_en;
    logic       I_div_clk;
    logic [7:0] o_high_cnt;
    logic [7:0] o_low_cnt;
    logic [8:0] o_ratio;
    logic       o_valid;
    logic       o_locked;
    logic       o_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        bit div;
        bit en;
        bit full;
        bit v;
        bit lk;
        bit er;
        int hi;
        int lo;
        int ra;
    } vec_t;

    vec_t tbl[$];

    clk_ratio_monitor #(.CNT_W(8), .LOCK_CNT(3)) dut (
        .I_ref_clk  (I_ref_clk),
        .I_rst_n    (I_rst_n),
        .I_mon_en   (I_mon_en),
        .I_div_clk  (I_div_clk),
        .o_high_cnt (o_high_cnt),
        .o_low_cnt  (o_low_cnt),
        .o_ratio    (o_ratio),
        .o_valid    (o_valid),
        .o_locked   (o_locked),
        .o_err      (o_err)
    );

    initial I_ref_clk = 1'b0;
    always #5 I_ref_clk = ~I_ref_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void row(input bit div, input bit en, input bit v, input int hi,
                                input int lo, input int ra, input bit lk, input bit er);
        vec_t r;
        r.div = div; r.en = en; r.full = 1'b1; r.v = v;
        r.hi = hi; r.lo = lo; r.ra = ra; r.lk = lk; r.er = er;
        tbl.push_back(r);
    endfunction

    function automatic void quiet(input bit div, input bit en, input int n);
        vec_t r;
        r.div = div; r.en = en; r.full = 1'b0; r.v = 1'b0;
        r.hi = 0; r.lo = 0; r.ra = 0; r.lk = 1'b0; r.er = 1'b0;
        for (int k = 0; k < n; k++) tbl.push_back(r);
    endfunction

    // One period entered just after a rise: h high samples, l low samples, then the closing rise.
    function automatic void per(input int h, input int l, input int eh, input int el,
                                input int era, input bit lk, input bit er);
        quiet(1'b1, 1'b1, h - 1);
        quiet(1'b0, 1'b1, l);
        row(1'b1, 1'b1, 1'b1, eh, el, era, lk, er);
    endfunction

    int row_no = 0;

    task automatic apply_table();
        foreach (tbl[i]) begin
            @(negedge I_ref_clk);
            I_div_clk = tbl[i].div;
            I_mon_en  = tbl[i].en;
            @(posedge I_ref_clk);
            #1;
            if (tbl[i].full) begin
                chk($sformatf("row%0d valid", row_no), o_valid, tbl[i].v);
                chk($sformatf("row%0d err", row_no), o_err, tbl[i].er);
                chk($sformatf("row%0d locked", row_no), o_locked, tbl[i].lk);
                chk($sformatf("row%0d high", row_no), o_high_cnt, tbl[i].hi);
                chk($sformatf("row%0d low", row_no), o_low_cnt, tbl[i].lo);
                chk($sformatf("row%0d ratio", row_no), o_ratio, tbl[i].ra);
            end else begin
                chk($sformatf("row%0d quiet valid/err", row_no), {o_valid, o_err}, 0);
            end
            row_no++;
        end
        tbl.delete();
    endtask

    initial begin
        int err_cnt;
        int err_at;
        int v_seen;

        I_rst_n   = 1'b0;
        I_mon_en  = 1'b0;
        I_div_clk = 1'b0;
        repeat (2) @(posedge I_ref_clk);
        #1;
        chk("reset valid", o_valid, 0);
        chk("reset err", o_err, 0);
        chk("reset locked", o_locked, 0);
        chk("reset high", o_high_cnt, 0);
        chk("reset low", o_low_cnt, 0);
        chk("reset ratio", o_ratio, 0);
        @(negedge I_ref_clk);
        I_rst_n = 1'b1;

        // Symmetric 2/2 from startup, lock on the third valid.
        quiet(1'b0, 1'b1, 1);
        quiet(1'b1, 1'b1, 1);
        per(2, 2, 2, 2, 4, 1'b0, 1'b0);
        per(2, 2, 2, 2, 4, 1'b0, 1'b0);
        per(2, 2, 2, 2, 4, 1'b1, 1'b0);
        per(2, 2, 2, 2, 4, 1'b1, 1'b0);
        // Disable, then odd ratio 3/2 from a fresh acquisition.
        row(1'b0, 1'b0, 1'b0, 2, 2, 4, 1'b0, 1'b0);
        quiet(1'b0, 1'b1, 1);
        quiet(1'b1, 1'b1, 1);
        per(3, 2, 3, 2, 5, 1'b0, 1'b0);
        per(3, 2, 3, 2, 5, 1'b0, 1'b0);
        per(3, 2, 3, 2, 5, 1'b1, 1'b0);
        per(3, 2, 3, 2, 5, 1'b1, 1'b0);
        // Ratio change while locked: 5 -> 4 -> 6.
        per(2, 2, 2, 2, 4, 1'b0, 1'b1);
        per(2, 2, 2, 2, 4, 1'b0, 1'b0);
        per(2, 2, 2, 2, 4, 1'b1, 1'b0);
        per(3, 3, 3, 3, 6, 1'b0, 1'b1);
        per(3, 3, 3, 3, 6, 1'b0, 1'b0);
        per(3, 3, 3, 3, 6, 1'b1, 1'b0);
        apply_table();

        // Stuck high while locked on 6.
        err_cnt = 0;
        err_at  = -1;
        v_seen  = 0;
        for (int i = 1; i < 300; i++) begin
            @(negedge I_ref_clk);
            I_div_clk = 1'b1;
            I_mon_en  = 1'b1;
            @(posedge I_ref_clk);
            #1;
            if (o_err) begin
                err_cnt++;
                err_at = i;
            end
            if (o_valid) v_seen++;
        end
        chk("timeout err pulses", err_cnt, 1);
        chk("timeout err delay", err_at, CNT_MAX);
        chk("timeout valid count", v_seen, 0);
        chk("timeout locked", o_locked, 0);
        chk("timeout ratio held", o_ratio, 6);

        quiet(1'b0, 1'b1, 2);
        row(1'b1, 1'b1, 1'b0, 3, 3, 6, 1'b0, 1'b0);
        per(2, 2, 2, 2, 4, 1'b0, 1'b0);
        // Enable while high: first high phase is discarded.
        row(1'b1, 1'b0, 1'b0, 2, 2, 4, 1'b0, 1'b0);
        quiet(1'b1, 1'b1, 5);
        quiet(1'b0, 1'b1, 2);
        quiet(1'b1, 1'b1, 1);
        per(2, 3, 2, 3, 5, 1'b0, 1'b0);
        per(2, 3, 2, 3, 5, 1'b0, 1'b0);
        per(2, 3, 2, 3, 5, 1'b1, 1'b0);
        // One-cycle disable mid-phase.
        quiet(1'b1, 1'b1, 1);
        row(1'b0, 1'b0, 1'b0, 2, 3, 5, 1'b0, 1'b0);
        quiet(1'b0, 1'b1, 2);
        row(1'b1, 1'b1, 1'b0, 2, 3, 5, 1'b0, 1'b0);
        per(3, 3, 3, 3, 6, 1'b0, 1'b0);
        quiet(1'b1, 1'b1, 1);
        apply_table();

        // Asynchronous reset between clock edges.
        @(negedge I_ref_clk);
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("async reset valid", o_valid, 0);
        chk("async reset locked", o_locked, 0);
        chk("async reset high", o_high_cnt, 0);
        chk("async reset low", o_low_cnt, 0);
        chk("async reset ratio", o_ratio, 0);
        @(posedge I_ref_clk);
        @(negedge I_ref_clk);
        I_rst_n   = 1'b1;
        I_mon_en  = 1'b0;
        I_div_clk = 1'b0;

        quiet(1'b0, 1'b1, 1);
        row(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        per(2, 2, 2, 2, 4, 1'b0, 1'b0);
        // Minimum period: toggle every cycle.
        per(1, 1, 1, 1, 2, 1'b0, 1'b0);
        per(1, 1, 1, 1, 2, 1'b0, 1'b0);
        per(1, 1, 1, 1, 2, 1'b1, 1'b0);
        apply_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
